// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state encoding, key codes and timer sizing for the combination lock
package lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_CHECK,
        ST_OPEN,
        ST_WRONG,
        ST_LOCKOUT
    } state_e;

    localparam logic [3:0] KEY_CLR   = 4'hA;
    localparam logic [3:0] KEY_ENT   = 4'hB;
    localparam logic [3:0] SEG_BLANK = 4'hF;

    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lock_if.sv
// rtl/lock_if.sv - keypad strobe and display/status bundle between keypad side and lock_ctrl
interface lock_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] seg_1;
    logic [3:0] seg_2;
    logic [3:0] seg_3;
    logic [3:0] seg_4;
    logic [3:0] count_wrong;
    logic       unlock;
    logic       alarm;
    logic       busy;

    modport master (
        output key_valid, key_code,
        input  seg_1, seg_2, seg_3, seg_4, count_wrong, unlock, alarm, busy
    );

    modport slave (
        input  key_valid, key_code,
        output seg_1, seg_2, seg_3, seg_4, count_wrong, unlock, alarm, busy
    );
endinterface

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - loadable down-counter shared by the OPEN hold and the LOCKOUT period
module lock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A load of N keeps the owner in its state for exactly N cycles.
    assign expired_o = !load_i && (count_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/lock_ctrl.sv
// rtl/lock_ctrl.sv - keypad sequencing, password check, attempt counting and lockout for the 4-digit lock
// Optional LOCKOUT_TIMER_EN: lockout ends after LOCK_CYCLES instead of holding until reset.
module lock_ctrl
    import lock_pkg::*;
#(
    parameter logic [15:0] PWD_DEFAULT = 16'h1234,
    parameter int          MAX_WRONG   = 3,
    parameter int          OPEN_CYCLES = 50_000_000,
    parameter int          LOCK_CYCLES = 500_000_000
) (
    input  logic clk,
    input  logic rst_n,
    lock_if.slave bus
);

    localparam int         TW      = timer_width(OPEN_CYCLES, LOCK_CYCLES);
    localparam logic [3:0] MAX_W   = 4'(MAX_WRONG);
    localparam logic [3:0] CNT_SAT = 4'd9;

    state_e     state_q, state_d;
    logic [3:0] digits_q [4];
    logic [3:0] digits_d [4];
    logic [2:0] ndig_q, ndig_d;
    logic [3:0] cnt_q, cnt_d;
    logic       unlock_q, unlock_d;
    logic       alarm_q, alarm_d;
    logic       busy_q, busy_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_value;
    logic          tmr_expired;

    lock_timer #(.W(TW)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .value_i   (tmr_value),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d   = state_q;
        digits_d  = digits_q;
        ndig_d    = ndig_q;
        cnt_d     = cnt_q;
        tmr_load  = 1'b0;
        tmr_value = '0;

        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (bus.key_valid) begin
                    if (bus.key_code <= 4'd9) begin
                        if (ndig_q < 3'd4) begin
                            digits_d[ndig_q[1:0]] = bus.key_code;
                            ndig_d                = ndig_q + 3'd1;
                            state_d               = ST_ENTRY;
                        end
                    end else if (bus.key_code == KEY_CLR) begin
                        digits_d = '{default: SEG_BLANK};
                        ndig_d   = 3'd0;
                        state_d  = ST_IDLE;
                    end else if (bus.key_code == KEY_ENT && ndig_q == 3'd4) begin
                        state_d = ST_CHECK;
                    end
                end
            end

            ST_CHECK: begin
                if ({digits_q[0], digits_q[1], digits_q[2], digits_q[3]} == PWD_DEFAULT) begin
                    state_d   = ST_OPEN;
                    cnt_d     = 4'd0;
                    tmr_load  = 1'b1;
                    tmr_value = TW'(OPEN_CYCLES);
                end else begin
                    cnt_d = (cnt_q >= CNT_SAT) ? CNT_SAT : cnt_q + 4'd1;
                    if (cnt_d >= MAX_W) begin
                        // Display goes blank for the whole lockout.
                        state_d  = ST_LOCKOUT;
                        digits_d = '{default: SEG_BLANK};
                        ndig_d   = 3'd0;
`ifdef LOCKOUT_TIMER_EN
                        tmr_load  = 1'b1;
                        tmr_value = TW'(LOCK_CYCLES);
`endif
                    end else begin
                        state_d = ST_WRONG;
                    end
                end
            end

            ST_OPEN: begin
                if (tmr_expired) begin
                    state_d  = ST_IDLE;
                    digits_d = '{default: SEG_BLANK};
                    ndig_d   = 3'd0;
                end
            end

            ST_WRONG: begin
                state_d  = ST_IDLE;
                digits_d = '{default: SEG_BLANK};
                ndig_d   = 3'd0;
            end

            ST_LOCKOUT: begin
`ifdef LOCKOUT_TIMER_EN
                if (tmr_expired) begin
                    state_d  = ST_IDLE;
                    cnt_d    = 4'd0;
                    digits_d = '{default: SEG_BLANK};
                    ndig_d   = 3'd0;
                end
`else
                state_d = ST_LOCKOUT;
`endif
            end

            default: begin
                state_d  = ST_IDLE;
                digits_d = '{default: SEG_BLANK};
                ndig_d   = 3'd0;
            end
        endcase

        unlock_d = (state_d == ST_OPEN);
        alarm_d  = (state_d == ST_LOCKOUT);
        busy_d   = (state_d inside {ST_CHECK, ST_OPEN, ST_LOCKOUT});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            digits_q <= '{default: SEG_BLANK};
            ndig_q   <= 3'd0;
            cnt_q    <= 4'd0;
            unlock_q <= 1'b0;
            alarm_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            ndig_q   <= ndig_d;
            cnt_q    <= cnt_d;
            unlock_q <= unlock_d;
            alarm_q  <= alarm_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.seg_1       = digits_q[0];
    assign bus.seg_2       = digits_q[1];
    assign bus.seg_3       = digits_q[2];
    assign bus.seg_4       = digits_q[3];
    assign bus.count_wrong = cnt_q;
    assign bus.unlock      = unlock_q;
    assign bus.alarm       = alarm_q;
    assign bus.busy        = busy_q;

endmodule
